// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encodings, mstatus field positions and privilege codes.
package csr_pkg;

    localparam logic [11:0] CSR_SSTATUS  = 12'h100;
    localparam logic [11:0] CSR_STVEC    = 12'h105;
    localparam logic [11:0] CSR_SSCRATCH = 12'h140;
    localparam logic [11:0] CSR_SEPC     = 12'h141;
    localparam logic [11:0] CSR_SCAUSE   = 12'h142;
    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam logic [1:0] OP_W    = 2'b00;
    localparam logic [1:0] OP_S    = 2'b01;
    localparam logic [1:0] OP_C    = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam int MS_SIE    = 1;
    localparam int MS_MIE    = 3;
    localparam int MS_SPIE   = 5;
    localparam int MS_MPIE   = 7;
    localparam int MS_SPP    = 8;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write datapath for csrrw/csrrs/csrrc; set/clear with a zero operand is not a write.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] new_val,
    output logic            do_write
);

    // Compute the candidate new value and whether it should commit
    always_comb begin
        new_val  = old_val;
        do_write = 1'b0;
        case (op)
            OP_W: begin
                new_val  = src;
                do_write = 1'b1;
            end
            OP_S: begin
                new_val  = old_val | src;
                do_write = |src;
            end
            OP_C: begin
                new_val  = old_val & ~src;
                do_write = |src;
            end
            default: begin
                new_val  = old_val;
                do_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_regfile.sv
// Architectural CSR storage, privilege mode, counters, trap entry and xRET redirect.
module csr_regfile
    import csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      csr_ctrl,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] zimm,
    input  logic            inst_valid,
    input  logic            inst_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal_csr,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv
);

    // sstatus exposes only SIE, SPIE and SPP of mstatus
    localparam logic [XLEN-1:0] SSTATUS_MASK =
        (XLEN'(1) << MS_SIE) | (XLEN'(1) << MS_SPIE) | (XLEN'(1) << MS_SPP);
    localparam logic [XLEN-1:0] LOW2_CLR = ~XLEN'(3);

    logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
    logic [XLEN-1:0] stvec, sscratch, sepc, scause, satp;
    logic [XLEN-1:0] mcycle, minstret;

    logic            csr_we, is_mret, is_sret, src_sel;
    logic [1:0]      op;
    logic [XLEN-1:0] rdata, src, alu_new;
    logic            implemented, alu_do_write;
    logic            take_trap, take_mret, take_sret, wr_en;

    assign csr_we  = csr_ctrl[5];
    assign is_mret = csr_ctrl[4];
    assign is_sret = csr_ctrl[3];
    assign src_sel = csr_ctrl[2];
    assign op      = csr_ctrl[1:0];

    // Address decode for the read port; unknown addresses read as zero
    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_SSTATUS:  rdata = mstatus & SSTATUS_MASK;
            CSR_STVEC:    rdata = stvec;
            CSR_SSCRATCH: rdata = sscratch;
            CSR_SEPC:     rdata = sepc;
            CSR_SCAUSE:   rdata = scause;
            CSR_SATP:     rdata = satp;
            CSR_MSTATUS:  rdata = mstatus;
            CSR_MIE:      rdata = mie;
            CSR_MTVEC:    rdata = mtvec;
            CSR_MSCRATCH: rdata = mscratch;
            CSR_MEPC:     rdata = mepc;
            CSR_MCAUSE:   rdata = mcause;
            CSR_MCYCLE:   rdata = mcycle;
            CSR_MINSTRET: rdata = minstret;
            default: begin
                rdata       = '0;
                implemented = 1'b0;
            end
        endcase
    end

    assign csr_rdata   = rdata;
    assign illegal_csr = inst_valid & csr_we & ~implemented;
    assign src         = src_sel ? zimm : rs1_data;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .op       (op),
        .old_val  (rdata),
        .src      (src),
        .new_val  (alu_new),
        .do_write (alu_do_write)
    );

    // A trap swallows any CSR op or return issued alongside it; mret beats sret
    assign take_trap = trap_valid;
    assign take_mret = inst_valid & is_mret & ~trap_valid;
    assign take_sret = inst_valid & is_sret & ~is_mret & ~trap_valid;
    assign wr_en     = inst_valid & csr_we & ~trap_valid & implemented & alu_do_write;

    // State update: counters, CSR writes, then trap/return overlays on mstatus and priv
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus        <= '0;
            mie            <= '0;
            mtvec          <= MTVEC_RESET;
            mscratch       <= '0;
            mepc           <= '0;
            mcause         <= '0;
            stvec          <= '0;
            sscratch       <= '0;
            sepc           <= '0;
            scause         <= '0;
            satp           <= '0;
            mcycle         <= '0;
            minstret       <= '0;
            priv           <= PRIV_M;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            mcycle <= mcycle + XLEN'(1);
            if (inst_retire) begin
                minstret <= minstret + XLEN'(1);
            end
            redirect_valid <= take_trap | take_mret | take_sret;

            if (wr_en) begin
                case (csr_addr)
                    CSR_SSTATUS:  mstatus  <= (mstatus & ~SSTATUS_MASK) | (alu_new & SSTATUS_MASK);
                    CSR_STVEC:    stvec    <= alu_new & LOW2_CLR;
                    CSR_SSCRATCH: sscratch <= alu_new;
                    CSR_SEPC:     sepc     <= alu_new & LOW2_CLR;
                    CSR_SCAUSE:   scause   <= alu_new;
                    CSR_SATP:     satp     <= alu_new;
                    CSR_MSTATUS:  mstatus  <= alu_new;
                    CSR_MIE:      mie      <= alu_new;
                    CSR_MTVEC:    mtvec    <= alu_new & LOW2_CLR;
                    CSR_MSCRATCH: mscratch <= alu_new;
                    CSR_MEPC:     mepc     <= alu_new & LOW2_CLR;
                    CSR_MCAUSE:   mcause   <= alu_new;
                    CSR_MCYCLE:   mcycle   <= alu_new;
                    CSR_MINSTRET: minstret <= alu_new;
                    default: ;
                endcase
            end

            if (take_trap) begin
                mepc                         <= trap_pc & LOW2_CLR;
                mcause                       <= trap_cause;
                mstatus[MS_MPIE]             <= mstatus[MS_MIE];
                mstatus[MS_MIE]              <= 1'b0;
                mstatus[MS_MPP_HI:MS_MPP_LO] <= priv;
                priv                         <= PRIV_M;
                redirect_pc                  <= {mtvec[XLEN-1:2], 2'b00};
            end else if (take_mret) begin
                priv                         <= mstatus[MS_MPP_HI:MS_MPP_LO];
                mstatus[MS_MIE]              <= mstatus[MS_MPIE];
                mstatus[MS_MPIE]             <= 1'b1;
                mstatus[MS_MPP_HI:MS_MPP_LO] <= PRIV_U;
                redirect_pc                  <= mepc;
            end else if (take_sret) begin
                priv                         <= {1'b0, mstatus[MS_SPP]};
                mstatus[MS_SIE]              <= mstatus[MS_SPIE];
                mstatus[MS_SPIE]             <= 1'b1;
                mstatus[MS_SPP]              <= 1'b0;
                redirect_pc                  <= sepc;
            end
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus randomized traffic against a reference model.
module tb_csr_regfile;

    localparam logic [63:0] MT_RST = 64'h0000_0000_0000_0100;
    localparam logic [63:0] SMASK  = 64'h122;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  csr_ctrl;
    logic [11:0] csr_addr;
    logic [63:0] rs1_data, zimm, trap_cause, trap_pc;
    logic        inst_valid, inst_retire, trap_valid;
    logic [63:0] csr_rdata, redirect_pc;
    logic        illegal_csr, redirect_valid;
    logic [1:0]  priv;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_regfile #(.XLEN(64), .MTVEC_RESET(MT_RST)) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_ctrl       (csr_ctrl),
        .csr_addr       (csr_addr),
        .rs1_data       (rs1_data),
        .zimm           (zimm),
        .inst_valid     (inst_valid),
        .inst_retire    (inst_retire),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .csr_rdata      (csr_rdata),
        .illegal_csr    (illegal_csr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .priv           (priv)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: CSR file as an address-keyed array, updated by architectural rules
    logic [11:0] impl_list [14] = '{12'h100, 12'h105, 12'h140, 12'h141, 12'h142, 12'h180,
                                    12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'hB00, 12'hB02};
    logic [63:0] m_csr [logic [11:0]];
    logic [1:0]  m_priv;
    logic        m_rv;
    logic [63:0] m_rpc;
    bit          model_ok = 0;

    function automatic bit m_impl(input logic [11:0] a);
        return (a == 12'h100) || m_csr.exists(a);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        if (a == 12'h100) return m_csr[12'h300] & SMASK;
        if (m_csr.exists(a)) return m_csr[a];
        return 64'h0;
    endfunction

    task automatic m_step();
        logic [63:0] ms, old, s, nv;
        bit w, cyc_w, ins_w, nrv;
        if (rst) begin
            for (int i = 0; i < 14; i++) m_csr[impl_list[i]] = 64'h0;
            m_csr[12'h305] = MT_RST;
            m_priv = 2'b11;
            m_rv = 1'b0;
            m_rpc = 64'h0;
            model_ok = 1;
            return;
        end
        cyc_w = 0; ins_w = 0; nrv = 0;
        ms = m_csr[12'h300];
        if (trap_valid) begin
            m_csr[12'h341] = trap_pc & ~64'h3;
            m_csr[12'h342] = trap_cause;
            ms[7] = ms[3];
            ms[3] = 1'b0;
            ms[12:11] = m_priv;
            m_csr[12'h300] = ms;
            m_priv = 2'b11;
            nrv = 1;
            m_rpc = m_csr[12'h305] & ~64'h3;
        end else begin
            if (inst_valid && csr_ctrl[5] && m_impl(csr_addr)) begin
                old = m_read(csr_addr);
                s = csr_ctrl[2] ? zimm : rs1_data;
                nv = old; w = 0;
                case (csr_ctrl[1:0])
                    2'b00: begin nv = s;        w = 1;       end
                    2'b01: begin nv = old | s;  w = (s != 0); end
                    2'b10: begin nv = old & ~s; w = (s != 0); end
                    default: w = 0;
                endcase
                if (w) begin
                    case (csr_addr)
                        12'h100: m_csr[12'h300] = (m_csr[12'h300] & ~SMASK) | (nv & SMASK);
                        12'h141, 12'h341, 12'h105, 12'h305: m_csr[csr_addr] = nv & ~64'h3;
                        default: m_csr[csr_addr] = nv;
                    endcase
                    if (csr_addr == 12'hB00) cyc_w = 1;
                    if (csr_addr == 12'hB02) ins_w = 1;
                end
            end
            ms = m_csr[12'h300];
            if (inst_valid && csr_ctrl[4]) begin
                m_priv = ms[12:11];
                ms[3] = ms[7];
                ms[7] = 1'b1;
                ms[12:11] = 2'b00;
                m_csr[12'h300] = ms;
                nrv = 1;
                m_rpc = m_csr[12'h341];
            end else if (inst_valid && csr_ctrl[3]) begin
                m_priv = {1'b0, ms[8]};
                ms[1] = ms[5];
                ms[5] = 1'b1;
                ms[8] = 1'b0;
                m_csr[12'h300] = ms;
                nrv = 1;
                m_rpc = m_csr[12'h141];
            end
        end
        if (!cyc_w) m_csr[12'hB00] = m_csr[12'hB00] + 64'h1;
        if (!ins_w && inst_retire) m_csr[12'hB02] = m_csr[12'hB02] + 64'h1;
        m_rv = nrv;
    endtask

    // First half of a cycle: settle at the falling edge and compare against the model
    task automatic half1();
        @(negedge clk);
        if (model_ok) begin
            chk("rdata", csr_rdata, m_read(csr_addr));
            chk("illegal", 64'(illegal_csr), 64'(inst_valid & csr_ctrl[5] & ~m_impl(csr_addr)));
            chk("priv", 64'(priv), 64'(m_priv));
            chk("redir_valid", 64'(redirect_valid), 64'(m_rv));
            chk("redir_pc", redirect_pc, m_rpc);
        end
    endtask

    task automatic half2();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic tick();
        half1();
        half2();
    endtask

    task automatic drive(input logic [5:0] c, input logic [11:0] a, input logic [63:0] r, input logic [63:0] z);
        rst = 0; trap_valid = 0; inst_retire = 0;
        inst_valid = 1; csr_ctrl = c; csr_addr = a; rs1_data = r; zimm = z;
    endtask

    task automatic rd(input logic [11:0] a);
        rst = 0; trap_valid = 0; inst_retire = 0;
        inst_valid = 0; csr_ctrl = 6'b000011; csr_addr = a; rs1_data = 0; zimm = 0;
    endtask

    initial begin
        logic [63:0] all1;
        int r;
        all1 = '1;
        rst = 1; csr_ctrl = 6'b000011; csr_addr = 0; rs1_data = 0; zimm = 0;
        inst_valid = 0; inst_retire = 0; trap_valid = 0; trap_cause = 0; trap_pc = 0;
        tick(); tick();

        // Reset values and free-running mcycle
        rd(12'h300); half1(); chk("rst_mstatus", csr_rdata, 64'h0); chk("rst_priv", 64'(priv), 64'h3); half2();
        rd(12'h305); half1(); chk("rst_mtvec", csr_rdata, MT_RST); half2();
        rd(12'hB02); half1(); chk("rst_minstret", csr_rdata, 64'h0); half2();
        rd(12'h304); tick(); tick();
        rd(12'hB00); half1(); chk("mcycle_5", csr_rdata, 64'd5); half2();

        // csrrw mepc, csrrsi mstatus, csrrc with zero operand
        drive(6'b100000, 12'h341, 64'h1003, 0); half1(); chk("rw_old", csr_rdata, 64'h0); half2();
        rd(12'h341); half1(); chk("mepc_align", csr_rdata, 64'h1000); half2();
        drive(6'b100101, 12'h300, 0, 64'd8); tick();
        rd(12'h300); half1(); chk("mie_set", csr_rdata, 64'h8); half2();
        drive(6'b100010, 12'h300, 0, 0); tick();
        rd(12'h300); half1(); chk("clr_zero", csr_rdata, 64'h8); half2();

        // Trap entry
        drive(6'b100000, 12'h305, 64'h200, 0); tick();
        rd(12'h0); trap_valid = 1; trap_cause = 64'd2; trap_pc = 64'h80; tick();
        rd(12'h341); half1();
        chk("trap_rv", 64'(redirect_valid), 64'h1); chk("trap_rpc", redirect_pc, 64'h200);
        chk("trap_mepc", csr_rdata, 64'h80); half2();
        rd(12'h342); half1(); chk("trap_rv_drop", 64'(redirect_valid), 64'h0); chk("trap_mcause", csr_rdata, 64'd2); half2();
        rd(12'h300); half1(); chk("trap_mstatus", csr_rdata, 64'h1880); half2();

        // mret to U, then sret to S
        drive(6'b100010, 12'h300, 64'h1800, 0); tick();
        drive(6'b100000, 12'h341, 64'h44, 0); tick();
        drive(6'b010011, 12'h0, 0, 0); tick();
        rd(12'h300); half1();
        chk("mret_rv", 64'(redirect_valid), 64'h1); chk("mret_rpc", redirect_pc, 64'h44);
        chk("mret_priv", 64'(priv), 64'h0); chk("mret_mstatus", csr_rdata, 64'h88); half2();
        drive(6'b100001, 12'h100, 64'h100, 0); tick();
        drive(6'b100000, 12'h141, 64'h90, 0); tick();
        drive(6'b001011, 12'h0, 0, 0); tick();
        rd(12'h100); half1();
        chk("sret_rpc", redirect_pc, 64'h90); chk("sret_priv", 64'(priv), 64'h1);
        chk("sret_sstatus", csr_rdata, 64'h20); half2();

        // Trap beats simultaneous csrrw and mret
        drive(6'b110000, 12'h340, 64'hDEAD, 0); trap_valid = 1; trap_cause = 64'd5; trap_pc = 64'h100; tick();
        rd(12'h340); half1();
        chk("prio_rpc", redirect_pc, 64'h200); chk("prio_mscratch", csr_rdata, 64'h0);
        chk("prio_priv", 64'(priv), 64'h3); half2();

        // mcycle wrap and unimplemented address
        drive(6'b100000, 12'hB00, all1, 0); tick();
        rd(12'hB00); half1(); chk("mcycle_ones", csr_rdata, all1); half2();
        rd(12'hB00); half1(); chk("mcycle_wrap", csr_rdata, 64'h0); half2();
        drive(6'b100000, 12'h7C0, 64'h55, 0); half1();
        chk("illegal_7c0", 64'(illegal_csr), 64'h1); chk("rd_7c0", csr_rdata, 64'h0); half2();

        // Reset during a trap
        rd(12'h0); trap_valid = 1; trap_cause = 64'd7; trap_pc = 64'h300; rst = 1; tick();
        rd(12'h341); half1();
        chk("rst_rv", 64'(redirect_valid), 64'h0); chk("rst_rpc", redirect_pc, 64'h0);
        chk("rst_mepc", csr_rdata, 64'h0); half2();
        rd(12'h305); half1(); chk("rst_mtvec2", csr_rdata, MT_RST); half2();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 15);
            if (r < 14) csr_addr = impl_list[r];
            else csr_addr = (r == 14) ? 12'h7C0 : 12'h301;
            inst_valid = ($urandom_range(0, 3) != 0);
            csr_ctrl = 6'($urandom);
            if (csr_ctrl[5] || $urandom_range(0, 2) != 0) csr_ctrl[4:3] = 2'b00;
            rs1_data = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
            zimm = 64'($urandom_range(0, 31));
            inst_retire = 1'($urandom);
            trap_valid = ($urandom_range(0, 15) == 0);
            trap_cause = {$urandom, $urandom};
            trap_pc = {$urandom, $urandom} & ~64'h3;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Architectural CSR state for the RV64 core: machine/supervisor CSR storage, privilege mode, cycle/instret counters, trap entry and mret/sret return.
- Sits directly downstream of the CSR decode controller. Consumes its 6-bit control vector (write enable, mret, sret, source select, op) and its zero-extended zimm.
- Returns the old CSR value for rd write-back and a registered PC redirect to the fetch stage.

Parameters:
- XLEN, 64, data width of CSRs, rs1 operand, PCs.
- MTVEC_RESET, 64'h0, reset value of mtvec.

Ports:
- clk  in  1  clock (all state on rising edge)
- rst  in  1  synchronous active-high reset
- csr_ctrl  in  6  decode vector: [5] csr_we, [4] mret, [3] sret, [2] src_sel (1=zimm, 0=rs1), [1:0] op (00 write, 01 set, 10 clear, 11 none)
- csr_addr  in  12  inst[31:20]
- rs1_data  in  XLEN  register operand
- zimm  in  XLEN  zero-extended inst[19:15]
- inst_valid  in  1  csr_ctrl is qualified this cycle
- inst_retire  in  1  one instruction retired this cycle
- trap_valid  in  1  exception taken this cycle
- trap_cause  in  XLEN  mcause value
- trap_pc  in  XLEN  faulting PC
- csr_rdata  out  XLEN  current (pre-write) value of csr_addr, combinational
- illegal_csr  out  1  inst_valid & csr_we & unimplemented address, combinational
- redirect_valid  out  1  registered, one-cycle pulse
- redirect_pc  out  XLEN  registered target
- priv  out  2  current mode (00 U, 01 S, 11 M)

Behaviour:
- Reset (sync, rst=1 at edge):
  - All CSRs = 0 except mtvec = MTVEC_RESET.
  - priv = 11.
  - redirect_valid = 0, redirect_pc = 0.
  - rst overrides every other input that cycle.
- Implemented CSRs (all others read 0; writes ignored and illegal_csr raised):
  - Machine: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342.
  - Supervisor: sstatus 100 (masked view of mstatus: SIE[1], SPIE[5], SPP[8]), stvec 105, sscratch 140, sepc 141, scause 142, satp 180.
  - Counters: mcycle B00, minstret B02.
- Operand: src = src_sel ? zimm : rs1_data. New value per op:
  - write: src
  - set: old | src
  - clear: old & ~src
- Write suppression: set/clear with src==0 perform no write. Write commits at the clock edge when inst_valid & csr_we & !trap_valid.
- mepc/sepc bits [1:0] written as 0. mtvec/stvec: direct mode only, target {tvec[63:2],2'b00}.
- Trap (trap_valid=1), highest priority; any CSR op or ret in the same cycle is dropped:
  - mepc ← trap_pc; mcause ← trap_cause.
  - MPIE ← MIE; MIE ← 0; MPP ← priv; priv ← 11.
  - Next cycle: redirect_valid=1, redirect_pc = mtvec target.
- mret (inst_valid & ctrl[4], no trap):
  - priv ← MPP; MIE ← MPIE; MPIE ← 1; MPP ← 00.
  - Next cycle: redirect to mepc.
- sret (inst_valid & ctrl[3], no trap):
  - priv ← {1'b0,SPP}; SIE ← SPIE; SPIE ← 1; SPP ← 0.
  - Next cycle: redirect to sepc.
- mret and sret both asserted: mret wins.
- Redirect latency is exactly 1 cycle. redirect_valid is high for one cycle unless a new trap or ret occurs in that cycle.
- Counters:
  - mcycle += 1 every non-reset cycle.
  - minstret += 1 when inst_retire.
  - An explicit CSR write to a counter in the same cycle takes precedence over its increment.
  - 64-bit wrap: all-ones → 0.
- Read-during-write: csr_rdata returns the old value; the new value is visible from the next cycle.
- No privilege checking of csr_addr in this block (the decode stage owns it).

Decomposition:
- csr_pkg holds:
  - CSR address localparams.
  - Op encodings (OP_W, OP_S, OP_C, OP_NONE).
  - mstatus bit indices (SIE 1, MIE 3, SPIE 5, MPIE 7, SPP 8, MPP 12:11).
  - Privilege encodings.
- One sub-module: csr_alu (combinational: op, old, src → new, do_write).
- Storage, trap logic and counters stay in csr_regfile.

Test Plan:
- Reset, then read 300/305/B02 → 0, MTVEC_RESET, 0; priv=11; read B00 after 5 cycles → 5.
- csrrw 341 with rs1=0x1003 → csr_rdata=0 that cycle; next read 341 = 0x1000. Then csrrsi 300 zimm=8 → MIE=1. Then csrrc 300 rs1=0 → no write, MIE still 1.
- trap_valid, cause=2, pc=0x80, mtvec=0x200, priv=11 → mepc=0x80, mcause=2, MIE=0, MPIE=1, MPP=11; next cycle redirect_valid=1, redirect_pc=0x200.
- Set MPP=00, mepc=0x44, then mret → priv=00, MIE=MPIE, MPP=00; next cycle redirect_pc=0x44. sret with SPP=1, sepc=0x90 → priv=01, redirect 0x90.
- trap_valid same cycle as csrrw 340 and mret → trap taken, mscratch unchanged, redirect to mtvec.
- Write mcycle=all-ones → next cycle 0. csrrw to 7C0 → illegal_csr=1, reads 0. rst asserted mid-trap → all state at reset values, no redirect.
